// File: rtl/ring_rr_arb.sv
// Round-robin arbiter with a one-hot ring priority token, a per-grant hold
// limit, and one dead cycle between grants.
module ring_rr_arb #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8,
   localparam int HW      = $clog2(MAX_HOLD)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          done,
   output logic [N-1:0]  gnt,
   output logic          gnt_valid,
   output logic [N-1:0]  ptr,
   output logic [HW-1:0] hold_cnt,
   output logic          timeout
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);
   localparam logic [N-1:0]  PTR_RST  = N'(1);

   state_t          state, state_nxt;
   logic [N-1:0]    gnt_nxt, ptr_nxt;
   logic [HW-1:0]   hold_nxt;
   logic            timeout_nxt;

   logic [N-1:0]    upper, masked, pick_src, pick;
   logic            gnt_req, at_lim, release_now;

   // Requesters at or above the token position win first; if none, the
   // lowest-indexed requester below the token wins (circular scan).
   assign upper    = ~(ptr - N'(1));
   assign masked   = req & upper;
   assign pick_src = (|masked) ? masked : req;
   assign pick     = pick_src & (~pick_src + N'(1));

   assign gnt_req     = |(req & gnt);
   assign at_lim      = (hold_cnt == HOLD_LIM);
   assign release_now = done | ~gnt_req | at_lim;

   always_comb begin
      state_nxt   = state;
      gnt_nxt     = gnt;
      ptr_nxt     = ptr;
      hold_nxt    = hold_cnt;
      timeout_nxt = 1'b0;
      unique case (state)
         IDLE: begin
            hold_nxt = '0;
            if (|req) begin
               gnt_nxt   = pick;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (release_now) begin
               gnt_nxt     = '0;
               ptr_nxt     = {gnt[N-2:0], gnt[N-1]};
               hold_nxt    = '0;
               // Only a pure hold-limit revocation counts as a timeout.
               timeout_nxt = at_lim & ~done & gnt_req;
               state_nxt   = IDLE;
            end else begin
               hold_nxt = hold_cnt + HW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         gnt      <= '0;
         ptr      <= PTR_RST;
         hold_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         state    <= state_nxt;
         gnt      <= gnt_nxt;
         ptr      <= ptr_nxt;
         hold_cnt <= hold_nxt;
         timeout  <= timeout_nxt;
      end
   end

   assign gnt_valid = |gnt;

endmodule
